// File: rtl/maxnet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_pkg
// Description : Shared types, constants and index helper for the Maxnet
//               winner-take-all sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package maxnet_pkg;

    localparam int c_MAXNET_N = 4;
    localparam int c_FP_W     = 32;
    localparam int c_MAX_N    = 32;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_PRECHK = 4'd2,
        S_ROW    = 4'd3,
        S_ISSUE  = 4'd4,
        S_WAIT   = 4'd5,
        S_WRITE  = 4'd6,
        S_COMMIT = 4'd7,
        S_CHECK  = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    // Lowest index above cur that is not skip and is set in mask; n when none.
    function automatic int next_idx(input int cur, input int skip,
                                    input logic [c_MAX_N-1:0] mask, input int n);
        int r;
        r = n;
        for (int k = c_MAX_N - 1; k >= 0; k--) begin
            if (k < n && k > cur && k != skip && mask[k]) begin
                r = k;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maxnet_onehot_check.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_onehot_check
// Description : Classifies a flag vector as none / exactly one / many set and
//               priority-encodes the lowest set flag.
// Revision    : 1.0  initial release
// ============================================================================
module maxnet_onehot_check #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_flags,
    output logic             o_zero,
    output logic             o_one,
    output logic             o_many,
    output logic [IDX_W-1:0] o_idx
);

    logic w_multi;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi = |(i_flags & (i_flags - N'(1)));
    assign o_zero  = ~|i_flags;
    assign o_one   = ~o_zero & ~w_multi;
    assign o_many  = w_multi;

    always_comb begin
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_flags[k]) begin
                o_idx = IDX_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/maxnet_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_sequencer
// Description : Control FSM sequencing one shared FP multiply-add across N
//               Maxnet neurons until at most one stays nonzero.
//               Build option: MAXNET_SKIP_ZERO_EN skips dead rows/columns.
// Revision    : 1.0  initial release
// ============================================================================
module maxnet_sequencer
    import maxnet_pkg::*;
#(
    parameter int N        = c_MAXNET_N,
    parameter int IDX_W    = 2,
    parameter int MAX_ITER = 64,
    parameter int ITER_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_fp_done,
    input  logic [N-1:0]      i_nz_flags,
    output logic              o_ld_init,
    output logic              o_acc_ld,
    output logic              o_fp_start,
    output logic [IDX_W-1:0]  o_sel_i,
    output logic [IDX_W-1:0]  o_sel_j,
    output logic              o_wr_en,
    output logic              o_commit,
    output logic              o_busy,
    output logic              o_finish,
    output logic              o_winner_vld,
    output logic [IDX_W-1:0]  o_winner_idx,
    output logic              o_timeout,
    output logic [ITER_W-1:0] o_iter_cnt
);

`ifdef MAXNET_SKIP_ZERO_EN
    localparam bit c_SKIP = 1'b1;
`else
    localparam bit c_SKIP = 1'b0;
`endif
    localparam logic [IDX_W-1:0]  c_LAST_ROW = IDX_W'(N - 1);
    localparam logic [ITER_W-1:0] c_MAX_ITER = ITER_W'(MAX_ITER);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_row;
    logic [IDX_W-1:0]    r_col;
    logic [ITER_W-1:0]   r_iter;
    logic                r_win_vld;
    logic [IDX_W-1:0]    r_win_idx;
    logic                r_timeout;

    logic [c_MAX_N-1:0]  w_mask;
    int                  w_first;
    int                  w_next;
    logic                w_first_ok;
    logic                w_next_ok;
    logic [IDX_W-1:0]    w_row_inc;
    logic                w_live0;
    logic                w_live_inc;
    logic                w_zero;
    logic                w_one;
    logic                w_many;
    logic [IDX_W-1:0]    w_idx;
    logic                w_stop;

    maxnet_onehot_check #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_onehot (
        .i_flags (i_nz_flags),
        .o_zero  (w_zero),
        .o_one   (w_one),
        .o_many  (w_many),
        .o_idx   (w_idx)
    );

    // Without skipping every column counts as live.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < N; k++) begin
            w_mask[k] = c_SKIP ? i_nz_flags[k] : 1'b1;
        end
    end

    assign w_first    = next_idx(-1, int'(r_row), w_mask, N);
    assign w_next     = next_idx(int'(r_col), int'(r_row), w_mask, N);
    assign w_first_ok = (w_first < N);
    assign w_next_ok  = (w_next < N);
    assign w_row_inc  = r_row + 1'b1;
    assign w_live0    = ~c_SKIP | i_nz_flags[0];
    assign w_live_inc = ~c_SKIP | i_nz_flags[w_row_inc];
    assign w_stop     = w_zero | w_one | (w_many & (r_iter == c_MAX_ITER));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE:    if (i_start) w_state_nxt = S_LOAD;
            S_LOAD:            w_state_nxt = S_PRECHK;
            S_PRECHK, S_CHECK: w_state_nxt = w_stop ? S_DONE : (w_live0 ? S_ROW : S_WRITE);
            S_ROW:             w_state_nxt = w_first_ok ? S_ISSUE : S_WRITE;
            S_ISSUE:           w_state_nxt = S_WAIT;
            S_WAIT:            if (i_fp_done) w_state_nxt = w_next_ok ? S_ISSUE : S_WRITE;
            S_WRITE: begin
                if (r_row == c_LAST_ROW) w_state_nxt = S_COMMIT;
                else                     w_state_nxt = w_live_inc ? S_ROW : S_WRITE;
            end
            S_COMMIT:          w_state_nxt = S_CHECK;
            default:           w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row     <= '0;
            r_col     <= '0;
            r_iter    <= '0;
            r_win_vld <= 1'b0;
            r_win_idx <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_row     <= '0;
                        r_col     <= '0;
                        r_iter    <= '0;
                        r_win_vld <= 1'b0;
                        r_win_idx <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                S_PRECHK, S_CHECK: begin
                    if (w_stop) begin
                        r_win_vld <= w_one;
                        r_win_idx <= w_one ? w_idx : '0;
                        r_timeout <= w_many;
                    end else begin
                        r_row <= '0;
                    end
                end
                S_ROW:    if (w_first_ok) r_col <= w_first[IDX_W-1:0];
                S_WAIT:   if (i_fp_done && w_next_ok) r_col <= w_next[IDX_W-1:0];
                S_WRITE:  if (r_row != c_LAST_ROW) r_row <= w_row_inc;
                S_COMMIT: r_iter <= r_iter + 1'b1;
                default:  ;
            endcase
        end
    end

    always_comb begin
        o_ld_init    = (r_state == S_LOAD);
        o_acc_ld     = (r_state == S_ROW);
        o_fp_start   = (r_state == S_ISSUE);
        o_wr_en      = (r_state == S_WRITE);
        o_commit     = (r_state == S_COMMIT);
        o_finish     = (r_state == S_DONE);
        o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
        o_sel_i      = r_row;
        o_sel_j      = r_col;
        o_winner_vld = r_win_vld;
        o_winner_idx = r_win_idx;
        o_timeout    = r_timeout;
        o_iter_cnt   = r_iter;
    end

endmodule
`default_nettype wire
